// File: rtl/can_field_tracker_if.sv
// Destuffed-bit strobe in, per-bit field label and captured control fields out,
// shared between a CAN bit destuffer / error monitor and can_field_tracker.
interface can_field_tracker_if;
    logic       i_Bit_Valid;
    logic       i_Data;
    logic       i_Error;
    logic [0:4] o_frame_field;
    logic [5:0] o_Index;
    logic       o_Ide;
    logic       o_Rtr;
    logic [3:0] o_Dlc;
    logic       o_Frame_Done;

    modport master (
        output i_Bit_Valid, i_Data, i_Error,
        input  o_frame_field, o_Index, o_Ide, o_Rtr, o_Dlc, o_Frame_Done
    );
    modport slave (
        input  i_Bit_Valid, i_Data, i_Error,
        output o_frame_field, o_Index, o_Ide, o_Rtr, o_Dlc, o_Frame_Done
    );
endinterface

// File: rtl/can_field_tracker.sv
// Labels each destuffed CAN bit with its frame field and in-field index.
// Define CAN_EXT_FRAME_EN to track extended (29-bit ID) frames; otherwise IDE=1 aborts to WAIT_IDLE.
module can_field_tracker #(
    parameter int IDLE_BITS = 11
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    can_field_tracker_if.slave bus
);
    localparam int CW = $clog2(IDLE_BITS + 1);

    typedef enum logic [4:0] {
        F_IDLE      = 5'b00000, F_SOF      = 5'b00001, F_ID_A    = 5'b00010,
        F_RTR       = 5'b00011, F_IDE      = 5'b00100, F_EOF     = 5'b00101,
        F_R0        = 5'b00110, F_DLC      = 5'b00111, F_DATA    = 5'b01000,
        F_CRC       = 5'b01001, F_ACK_SLOT = 5'b01010, F_ID_B    = 5'b01100,
        F_R1        = 5'b01101, F_IFS      = 5'b01110, F_CRC_DEL = 5'b10001,
        F_ACK_DEL   = 5'b10010, F_WAIT_IDLE = 5'b11111
    } field_e;

    // Internal states differ from field codes: SRR and the extended RTR share one label.
    typedef enum logic [4:0] {
        S_IDLE, S_ID_A, S_SRR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC, S_CRC_DEL,
        S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS, S_WAIT_IDLE
`ifdef CAN_EXT_FRAME_EN
        , S_ID_B, S_RTR_B, S_R1
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [CW-1:0] rec_q, rec_d;
    logic [5:0]    data_last_q, data_last_d;
    field_e        field_q, field_d;
    logic [5:0]    index_q, index_d;
    logic          ide_q, ide_d;
    logic          rtr_q, rtr_d;
    logic [3:0]    dlc_q, dlc_d;
    logic          done_q, done_d;

    logic [3:0]    dlc_shift;
    logic [3:0]    n_bytes;

    assign dlc_shift = {dlc_q[2:0], bus.i_Data};
    assign n_bytes   = rtr_q ? 4'd0 : ((dlc_shift > 4'd8) ? 4'd8 : dlc_shift);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rec_q       <= '0;
            data_last_q <= '0;
            field_q     <= F_IDLE;
            index_q     <= '0;
            ide_q       <= 1'b0;
            rtr_q       <= 1'b0;
            dlc_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rec_q       <= rec_d;
            data_last_q <= data_last_d;
            field_q     <= field_d;
            index_q     <= index_d;
            ide_q       <= ide_d;
            rtr_q       <= rtr_d;
            dlc_q       <= dlc_d;
            done_q      <= done_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rec_d       = rec_q;
        data_last_d = data_last_q;
        if (bus.i_Error) begin
            state_d = S_WAIT_IDLE;
            idx_d   = '0;
            rec_d   = '0;
        end else if (bus.i_Bit_Valid) begin
            idx_d = idx_q + 6'd1;
            unique case (state_q)
                S_IDLE: begin
                    idx_d = '0;
                    if (!bus.i_Data) state_d = S_ID_A;
                end
                S_ID_A:     if (idx_q == 6'd10) begin state_d = S_SRR; idx_d = '0; end
                S_SRR:      begin state_d = S_IDE; idx_d = '0; end
                S_IDE: begin
                    idx_d = '0;
                    if (!bus.i_Data) state_d = S_R0;
`ifdef CAN_EXT_FRAME_EN
                    else             state_d = S_ID_B;
`else
                    else begin
                        state_d = S_WAIT_IDLE;
                        rec_d   = '0;
                    end
`endif
                end
`ifdef CAN_EXT_FRAME_EN
                S_ID_B:     if (idx_q == 6'd17) begin state_d = S_RTR_B; idx_d = '0; end
                S_RTR_B:    begin state_d = S_R1; idx_d = '0; end
                S_R1:       begin state_d = S_R0; idx_d = '0; end
`endif
                S_R0:       begin state_d = S_DLC; idx_d = '0; end
                S_DLC: if (idx_q == 6'd3) begin
                    idx_d       = '0;
                    state_d     = (n_bytes == 4'd0) ? S_CRC : S_DATA;
                    data_last_d = 6'({n_bytes, 3'b000} - 7'd1);
                end
                S_DATA:     if (idx_q == data_last_q) begin state_d = S_CRC; idx_d = '0; end
                S_CRC:      if (idx_q == 6'd14) begin state_d = S_CRC_DEL; idx_d = '0; end
                S_CRC_DEL:  begin state_d = S_ACK_SLOT; idx_d = '0; end
                S_ACK_SLOT: begin state_d = S_ACK_DEL; idx_d = '0; end
                S_ACK_DEL:  begin state_d = S_EOF; idx_d = '0; end
                S_EOF:      if (idx_q == 6'd6) begin state_d = S_IFS; idx_d = '0; end
                S_IFS: begin
                    if (!bus.i_Data) begin
                        idx_d   = '0;
                        rec_d   = '0;
                        state_d = (idx_q == 6'd2) ? S_ID_A : S_WAIT_IDLE;
                    end else if (idx_q == 6'd2) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end
                end
                S_WAIT_IDLE: begin
                    if (idx_q == 6'd63) idx_d = idx_q;
                    if (!bus.i_Data) begin
                        rec_d = '0;
                    end else if (rec_q == CW'(IDLE_BITS - 1)) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        rec_d   = '0;
                    end else begin
                        rec_d = rec_q + CW'(1);
                    end
                end
                default: begin state_d = S_IDLE; idx_d = '0; end
            endcase
        end
    end

    always_comb begin
        field_d = field_q;
        index_d = index_q;
        done_d  = 1'b0;
        ide_d   = ide_q;
        rtr_d   = rtr_q;
        dlc_d   = dlc_q;
        if (bus.i_Error) begin
            field_d = F_WAIT_IDLE;
            index_d = '0;
        end else if (bus.i_Bit_Valid) begin
            index_d = idx_q;
            unique case (state_q)
                S_IDLE: begin
                    index_d = '0;
                    if (bus.i_Data) field_d = F_IDLE;
                    else begin
                        field_d = F_SOF;
                        ide_d   = 1'b0;
                        rtr_d   = 1'b0;
                        dlc_d   = '0;
                    end
                end
                S_ID_A:     field_d = F_ID_A;
                S_SRR:      begin field_d = F_RTR; rtr_d = bus.i_Data; end
                S_IDE:      begin field_d = F_IDE; ide_d = bus.i_Data; end
`ifdef CAN_EXT_FRAME_EN
                S_ID_B:     field_d = F_ID_B;
                S_RTR_B:    begin field_d = F_RTR; rtr_d = bus.i_Data; end
                S_R1:       field_d = F_R1;
`endif
                S_R0:       field_d = F_R0;
                S_DLC:      begin field_d = F_DLC; dlc_d = dlc_shift; end
                S_DATA:     field_d = F_DATA;
                S_CRC:      field_d = F_CRC;
                S_CRC_DEL:  field_d = F_CRC_DEL;
                S_ACK_SLOT: field_d = F_ACK_SLOT;
                S_ACK_DEL:  field_d = F_ACK_DEL;
                S_EOF:      begin field_d = F_EOF; done_d = (idx_q == 6'd6); end
                S_IFS: begin
                    if (!bus.i_Data && idx_q == 6'd2) begin
                        field_d = F_SOF;
                        index_d = '0;
                        ide_d   = 1'b0;
                        rtr_d   = 1'b0;
                        dlc_d   = '0;
                    end else begin
                        field_d = F_IFS;
                    end
                end
                S_WAIT_IDLE: field_d = F_WAIT_IDLE;
                default:     begin field_d = F_IDLE; index_d = '0; end
            endcase
        end
    end

    assign bus.o_frame_field = field_q;
    assign bus.o_Index       = index_q;
    assign bus.o_Ide         = ide_q;
    assign bus.o_Rtr         = rtr_q;
    assign bus.o_Dlc         = dlc_q;
    assign bus.o_Frame_Done  = done_q;
endmodule

// File: tb/tb_can_field_tracker.sv
// Randomized bench for can_field_tracker: frames are described field by field and the
// expected (field, index) label of every bit is queued before the bits are driven.
module tb_can_field_tracker;
    localparam int IDLE_BITS = 11;

    localparam logic [4:0] C_IDLE = 5'b00000, C_SOF = 5'b00001, C_ID_A = 5'b00010,
                           C_RTR = 5'b00011, C_IDE = 5'b00100, C_EOF = 5'b00101,
                           C_R0 = 5'b00110, C_DLC = 5'b00111, C_DATA = 5'b01000,
                           C_CRC = 5'b01001, C_ACK_SLOT = 5'b01010, C_ID_B = 5'b01100,
                           C_R1 = 5'b01101, C_IFS = 5'b01110, C_CRC_DEL = 5'b10001,
                           C_ACK_DEL = 5'b10010, C_WAIT_IDLE = 5'b11111;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    can_field_tracker_if bus ();

    can_field_tracker #(.IDLE_BITS(IDLE_BITS)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    logic       exp_bit[$];
    logic [4:0] exp_fld[$];
    int         exp_idx[$];
    logic [5:0] exp_cap[$];   // {ide, rtr, dlc} expected when the frame completes

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic add(input logic [4:0] code, input int n, input logic [63:0] val, input int start = 0);
        for (int i = 0; i < n; i++) begin
            exp_bit.push_back(val[n-1-i]);
            exp_fld.push_back(code);
            exp_idx.push_back(start + i);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // tail: 0 = full IFS then one idle bit, 1 = two IFS bits (next frame's SOF follows),
    //       2 = dominant bit inside IFS, then WAIT_IDLE and one idle bit
    task automatic build_frame(input bit ext, input bit rtr, input logic [3:0] dlc, input int tail);
        int n;
        int k;
        add(C_SOF, 1, 64'd0);
        add(C_ID_A, 11, r64());
        if (ext) begin
            add(C_RTR, 1, '1);
            add(C_IDE, 1, '1);
`ifdef CAN_EXT_FRAME_EN
            add(C_ID_B, 18, r64());
            add(C_RTR, 1, 64'(rtr));
            add(C_R1, 1, r64());
            add(C_R0, 1, r64());
`else
            add(C_WAIT_IDLE, IDLE_BITS, '1);
            add(C_IDLE, 1, '1);
            return;
`endif
        end else begin
            add(C_RTR, 1, 64'(rtr));
            add(C_IDE, 1, 64'd0);
            add(C_R0, 1, r64());
        end
        add(C_DLC, 4, 64'(dlc));
        n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        if (n > 0) add(C_DATA, 8 * n, r64());
        add(C_CRC, 15, r64());
        add(C_CRC_DEL, 1, r64());
        add(C_ACK_SLOT, 1, r64());
        add(C_ACK_DEL, 1, r64());
        add(C_EOF, 7, r64());
        exp_cap.push_back({ext, rtr, dlc});
        case (tail)
            0: begin add(C_IFS, 3, '1); add(C_IDLE, 1, '1); end
            1: add(C_IFS, 2, '1);
            default: begin
                k = int'($urandom_range(0, 1));
                add(C_IFS, k, '1);
                add(C_IFS, 1, 64'd0, k);
                add(C_WAIT_IDLE, IDLE_BITS, '1);
                add(C_IDLE, 1, '1);
            end
        endcase
    endtask

    task automatic send_bit(input logic b, input logic err);
        @(negedge clk);
        bus.i_Bit_Valid = 1'b1;
        bus.i_Data      = b;
        bus.i_Error     = err;
        @(posedge clk);
        #1;
        bus.i_Bit_Valid = 1'b0;
        bus.i_Error     = 1'b0;
    endtask

    task automatic run_bits(input int count);
        logic       b;
        logic [4:0] f;
        int         ix;
        logic       dn;
        logic [5:0] cap;
        for (int i = 0; i < count && exp_bit.size() > 0; i++) begin
            b  = exp_bit.pop_front();
            f  = exp_fld.pop_front();
            ix = exp_idx.pop_front();
            send_bit(b, 1'b0);
            dn = (f == C_EOF) && (ix == 6);
            check("field", 64'(bus.o_frame_field), 64'(f));
            check("index", 64'(bus.o_Index), 64'(ix));
            check("done", 64'(bus.o_Frame_Done), 64'(dn));
            if (dn && exp_cap.size() > 0) begin
                cap = exp_cap.pop_front();
                check("ide", 64'(bus.o_Ide), 64'(cap[5]));
                check("rtr", 64'(bus.o_Rtr), 64'(cap[4]));
                check("dlc", 64'(bus.o_Dlc), 64'(cap[3:0]));
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                check("hold_field", 64'(bus.o_frame_field), 64'(f));
                check("hold_done", 64'(bus.o_Frame_Done), 64'd0);
            end
        end
    endtask

    function automatic int find_pos(input logic [4:0] f, input int ix);
        for (int i = 0; i < exp_fld.size(); i++)
            if (exp_fld[i] == f && exp_idx[i] == ix) return i;
        return -1;
    endfunction

    task automatic clear_model();
        exp_bit.delete();
        exp_fld.delete();
        exp_idx.delete();
        exp_cap.delete();
    endtask

    initial begin
        int pos;
        int tail;
        rst             = 1'b1;
        bus.i_Bit_Valid = 1'b0;
        bus.i_Data      = 1'b1;
        bus.i_Error     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_field", 64'(bus.o_frame_field), 64'(C_IDLE));
        check("rst_index", 64'(bus.o_Index), 64'd0);
        check("rst_dlc", 64'({bus.o_Ide, bus.o_Rtr, bus.o_Dlc}), 64'd0);
        check("rst_done", 64'(bus.o_Frame_Done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Standard data frame, remote frame with DLC 5, extended frame
        add(C_IDLE, 1, '1);
        build_frame(1'b0, 1'b0, 4'd2, 0);
        build_frame(1'b0, 1'b1, 4'd5, 0);
        build_frame(1'b1, 1'b0, 4'd1, 0);
        // Back-to-back frame started at IFS index 2, then dominant inside IFS
        build_frame(1'b0, 1'b0, 4'd3, 1);
        build_frame(1'b0, 1'b0, 4'd1, 2);
        run_bits(exp_bit.size());

        // Randomized frames
        for (int i = 0; i < 24; i++) begin
            tail = (i == 23) ? 0 : int'($urandom_range(0, 2));
            build_frame($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                        4'($urandom_range(0, 15)), tail);
        end
        run_bits(exp_bit.size());

        // Error during DATA index 3, with a bit strobe on the same clock
        build_frame(1'b0, 1'b0, 4'd4, 0);
        pos = find_pos(C_DATA, 3);
        run_bits(pos + 1);
        clear_model();
        send_bit(1'($urandom), 1'b1);
        check("err_field", 64'(bus.o_frame_field), 64'(C_WAIT_IDLE));
        check("err_index", 64'(bus.o_Index), 64'd0);
        add(C_WAIT_IDLE, 10, '1);
        add(C_WAIT_IDLE, 1, 64'd0, 10);
        add(C_WAIT_IDLE, IDLE_BITS, '1, 11);
        add(C_IDLE, 1, '1);
        build_frame(1'b0, 1'b0, 4'($urandom_range(0, 15)), 0);
        run_bits(exp_bit.size());

        // Error strobe without a bit, from IDLE
        @(negedge clk);
        bus.i_Error = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Error = 1'b0;
        check("err2_field", 64'(bus.o_frame_field), 64'(C_WAIT_IDLE));
        add(C_WAIT_IDLE, IDLE_BITS, '1);
        build_frame(1'b0, 1'b0, 4'd6, 0);
        run_bits(exp_bit.size());

        // Asynchronous reset at CRC index 7
        build_frame(1'b0, 1'b0, 4'd8, 0);
        pos = find_pos(C_CRC, 7);
        run_bits(pos + 1);
        check("pre_rst_dlc", 64'(bus.o_Dlc), 64'd8);
        #2;
        rst = 1'b1;
        #1;
        check("arst_field", 64'(bus.o_frame_field), 64'(C_IDLE));
        check("arst_index", 64'(bus.o_Index), 64'd0);
        check("arst_caps", 64'({bus.o_Ide, bus.o_Rtr, bus.o_Dlc}), 64'd0);
        check("arst_done", 64'(bus.o_Frame_Done), 64'd0);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        add(C_IDLE, 1, '1);
        build_frame(1'b0, 1'b0, 4'($urandom_range(0, 15)), 0);
        run_bits(exp_bit.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
